deltasigma_adc: RTL and testbench

First-order delta-sigma ADC front end plus sinc² decimator; the receive-side counterpart of the delta-sigma DAC. Samples an external comparator output (analog in vs. RC-filtered feedback), drives the feedback pin with the registered bitstream, and decimates the bit density into RESO-bit samples with a one-cycle valid strobe. It feeds envelope/level logic in the sound path and also serves as a loopback checker for the DAC output.

---
 rtl/deltasigma_pkg.sv | 31 +++
 rtl/cic_sinc2_decim.sv | 87 ++++++++
 rtl/deltasigma_adc.sv | 50 +++++
 tb/tb_deltasigma_adc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/deltasigma_pkg.sv
// Shared sizing, sample-extraction helpers and warm-up states for the
// delta-sigma receive path and any later CIC decimators.
package deltasigma_pkg;

    localparam int DEFAULT_DEC_LOG2 = 6;
    localparam int DEFAULT_RESO     = 6;

    typedef enum logic [1:0] {
        WU_IDLE = 2'd0,
        WU_ONE  = 2'd1,
        WU_DONE = 2'd2
    } warmup_t;

    // The extra bit above 2*decLog2 holds the full-scale value R^2 without wrapping.
    function automatic int cicWidth(input int decLog2);
        return 2 * decLog2 + 1;
    endfunction

    function automatic int accBits(input int decLog2);
        return 2 * decLog2;
    endfunction

    function automatic int sliceLsb(input int decLog2, input int reso);
        return accBits(decLog2) - reso;
    endfunction

    function automatic bit resoFits(input int reso, input int decLog2);
        return (reso >= 1) && (reso <= accBits(decLog2));
    endfunction

endpackage

// File: rtl/cic_sinc2_decim.sv
// Second-order CIC decimator: integrators, phase counter, combs,
// saturation to R^2-1, warm-up suppression and the output register.
module cic_sinc2_decim
    import deltasigma_pkg::*;
#(
    parameter int DEC_LOG2 = DEFAULT_DEC_LOG2,
    parameter int RESO     = DEFAULT_RESO
) (
    input  logic            i_clk,
    input  logic            i_res_n,
    input  logic            i_bit,
    output logic [RESO-1:0] o_data,
    output logic            o_valid
);

    localparam int W   = cicWidth(DEC_LOG2);
    localparam int ACC = accBits(DEC_LOG2);
    localparam int LSB = sliceLsb(DEC_LOG2, RESO);
    localparam logic [W-1:0]        FULL_SCALE = {1'b1, {ACC{1'b0}}};
    localparam logic [DEC_LOG2-1:0] LAST_PHASE = '1;

    logic [W-1:0]        r_int1;
    logic [W-1:0]        r_int2;
    logic [W-1:0]        r_int2d;
    logic [W-1:0]        r_comb1d;
    logic [DEC_LOG2-1:0] r_phase;
    logic [RESO-1:0]     r_data;
    logic                r_valid;
    warmup_t             r_wu;

    warmup_t             w_wuNext;
    logic                w_validNext;
    logic                w_dump;
    logic [W-1:0]        w_comb1;
    logic [W-1:0]        w_comb2;
    logic [RESO-1:0]     w_sample;

    assign w_dump   = (r_phase == LAST_PHASE);
    assign w_comb1  = r_int2 - r_int2d;
    assign w_comb2  = w_comb1 - r_comb1d;
    // Only C2 == R^2 reaches the top bit, so clamping it gives R^2-1 rather than 0.
    assign w_sample = (w_comb2 >= FULL_SCALE) ? '1 : w_comb2[LSB +: RESO];

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_int1   <= '0;
            r_int2   <= '0;
            r_int2d  <= '0;
            r_comb1d <= '0;
            r_phase  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_wu     <= WU_IDLE;
        end else begin
            r_int1  <= r_int1 + W'(i_bit);
            r_int2  <= r_int2 + r_int1;
            r_phase <= r_phase + DEC_LOG2'(1);
            r_valid <= w_validNext;
            r_wu    <= w_wuNext;
            if (w_dump) begin
                r_int2d  <= r_int2;
                r_comb1d <= w_comb1;
                r_data   <= w_sample;
            end
        end
    end

    // The first two dump results come from partly filled combs and are not announced.
    always_comb begin
        w_wuNext    = r_wu;
        w_validNext = 1'b0;
        if (w_dump) begin
            case (r_wu)
                WU_IDLE: w_wuNext = WU_ONE;
                WU_ONE:  w_wuNext = WU_DONE;
                default: begin
                    w_wuNext    = WU_DONE;
                    w_validNext = 1'b1;
                end
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/deltasigma_adc.sv
// Delta-sigma ADC front end: comparator synchroniser driving the feedback
// pin, followed by the sinc^2 decimator.
module deltasigma_adc
    import deltasigma_pkg::*;
#(
    parameter int RESO     = DEFAULT_RESO,
    parameter int DEC_LOG2 = DEFAULT_DEC_LOG2
) (
    input  logic            i_clk,
    input  logic            i_res_n,
    input  logic            i_cmp,
    output logic            o_fb,
    output logic [RESO-1:0] o_data,
    output logic            o_valid
);

    logic r_sync1;
    logic r_sync2;

    generate
        if (!resoFits(RESO, DEC_LOG2)) begin : g_badParams
            $error("deltasigma_adc: RESO must be between 1 and 2*DEC_LOG2");
        end
    endgenerate

    // The comparator is asynchronous; the second flop is the modulator bit.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_cmp;
            r_sync2 <= r_sync1;
        end
    end

    assign o_fb = r_sync2;

    cic_sinc2_decim #(
        .DEC_LOG2 (DEC_LOG2),
        .RESO     (RESO)
    ) u_decim (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .i_bit   (r_sync2),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

endmodule

// File: tb/tb_deltasigma_adc.sv
// Directed bench for deltasigma_adc: default R=64 instance plus an R=16, RESO=8
// instance for the full-scale saturation case.
module tb_deltasigma_adc;

    localparam int R  = 64;
    localparam int R2 = 16;

    logic       i_clk;
    logic       i_res_n;
    logic       i_cmp;
    logic       o_fb;
    logic [5:0] o_data;
    logic       o_valid;

    logic       i_res2_n;
    logic       i_cmp2;
    logic       o_fb2;
    logic [7:0] o_data2;
    logic       o_valid2;

    int cyc;
    int mode;
    int nTests;
    int nFail;

    deltasigma_adc dut (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .i_cmp   (i_cmp),
        .o_fb    (o_fb),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    deltasigma_adc #(
        .RESO     (8),
        .DEC_LOG2 (4)
    ) dut4 (
        .i_clk   (i_clk),
        .i_res_n (i_res2_n),
        .i_cmp   (i_cmp2),
        .o_fb    (o_fb2),
        .o_data  (o_data2),
        .o_valid (o_valid2)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Comparator patterns: 0 = all zeros, 1 = all ones, 2 = 1/0 alternating, 3 = 1000 repeating.
    function automatic logic patBit(input int m, input int c);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (c % 2) == 0;
            default: return (c % 4) == 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nTests++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge i_clk);
        #1;
        cyc++;
        i_cmp = patBit(mode, cyc);
    endtask

    task automatic doReset(input int newMode);
        mode    = newMode;
        i_res_n = 1'b0;
        i_cmp   = patBit(mode, 0);
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset_fb", 32'(o_fb), 0);
        checkOutput("reset_data", 32'(o_data), 0);
        checkOutput("reset_valid", 32'(o_valid), 0);
        i_res_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic runTo(input int endCyc, input int expData, input int fbExp, input bit holdCheck);
        bit strobe;
        while (cyc < endCyc) begin
            applyStimulus();
            strobe = (cyc >= 3 * R) && ((cyc % R) == 0);
            checkOutput("valid", 32'(o_valid), 32'(strobe));
            if (expData >= 0 && (strobe || (holdCheck && cyc >= 3 * R)))
                checkOutput("data", 32'(o_data), expData);
            if (fbExp >= 0)
                checkOutput("fb", 32'(o_fb), fbExp);
        end
    endtask

    initial begin
        bit strobe;
        nTests   = 0;
        nFail    = 0;
        cyc      = 0;
        mode     = 1;
        i_res_n  = 1'b0;
        i_res2_n = 1'b0;
        i_cmp    = 1'b0;
        i_cmp2   = 1'b1;

        // Full-scale ones: fb after 2 cycles, first strobe at 192 carries 63.
        doReset(1);
        applyStimulus();
        checkOutput("fb_cycle1", 32'(o_fb), 0);
        applyStimulus();
        checkOutput("fb_cycle2", 32'(o_fb), 1);
        runTo(3 * R + 2 * R, 63, 1, 1'b1);

        // All zeros: strobes still run, data zero, feedback zero.
        doReset(0);
        runTo(3 * R + 2 * R, 0, 0, 1'b1);

        // Alternating: half scale.
        doReset(2);
        runTo(3 * R + 3 * R, 32, -1, 1'b1);

        // 1000 pattern then a step to alternating, landing two cycles before the dump at 320.
        doReset(3);
        runTo(317, 16, -1, 1'b1);
        mode  = 2;
        i_cmp = patBit(mode, cyc);
        runTo(320, 16, -1, 1'b1);
        runTo(384, -1, -1, 1'b0);
        checkOutput("step_intermediate", 32'((o_data > 6'd16) && (o_data < 6'd32)), 1);
        runTo(512, 32, -1, 1'b0);

        // Reset pulse at cnt = 30 in steady state.
        runTo(542, 32, -1, 1'b1);
        i_res_n = 1'b0;
        #2;
        checkOutput("midreset_data", 32'(o_data), 0);
        checkOutput("midreset_valid", 32'(o_valid), 0);
        checkOutput("midreset_fb", 32'(o_fb), 0);
        @(posedge i_clk);
        #1;
        i_res_n = 1'b1;
        cyc     = 0;
        i_cmp   = patBit(mode, 0);
        runTo(3 * R, 32, -1, 1'b0);

        // Reset while o_valid is high drops the strobe at once.
        i_res_n = 1'b0;
        #2;
        checkOutput("strobe_reset_valid", 32'(o_valid), 0);
        checkOutput("strobe_reset_data", 32'(o_data), 0);

        // Small instance: R = 16, full scale 256 saturates to 255.
        checkOutput("r16_reset_data", 32'(o_data2), 0);
        checkOutput("r16_reset_valid", 32'(o_valid2), 0);
        checkOutput("r16_reset_fb", 32'(o_fb2), 0);
        @(posedge i_clk);
        #1;
        i_res2_n = 1'b1;
        cyc      = 0;
        for (int k = 1; k <= 7 * R2; k++) begin
            @(posedge i_clk);
            #1;
            cyc    = k;
            strobe = (k >= 3 * R2) && ((k % R2) == 0);
            checkOutput("r16_valid", 32'(o_valid2), 32'(strobe));
            if (k >= 3 * R2)
                checkOutput("r16_data", 32'(o_data2), 255);
            if (k >= 2)
                checkOutput("r16_fb", 32'(o_fb2), 1);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
